// File: rtl/sram_arbiter.sv
// sram_arbiter: round-robin two-master arbiter for the external SRAM port,
// grant locked per transaction, with a watchdog that force-completes hung slave accesses.
module sram_arbiter #(
  parameter int unsigned            ADDR_WIDTH     = 19,
  parameter int unsigned            DATA_WIDTH     = 32,
  parameter int unsigned            TIMEOUT_CYCLES = 1024,
  parameter logic [DATA_WIDTH-1:0]  TIMEOUT_DATA   = 32'hDEAD_BEEF
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    m0_valid_i,
  input  logic [ADDR_WIDTH-1:0]   m0_addr_i,
  input  logic [DATA_WIDTH-1:0]   m0_wdata_i,
  input  logic [DATA_WIDTH/8-1:0] m0_wstrb_i,
  output logic [DATA_WIDTH-1:0]   m0_rdata_o,
  output logic                    m0_ready_o,
  input  logic                    m1_valid_i,
  input  logic [ADDR_WIDTH-1:0]   m1_addr_i,
  input  logic [DATA_WIDTH-1:0]   m1_wdata_i,
  input  logic [DATA_WIDTH/8-1:0] m1_wstrb_i,
  output logic [DATA_WIDTH-1:0]   m1_rdata_o,
  output logic                    m1_ready_o,
  output logic                    s_valid_o,
  output logic [ADDR_WIDTH-1:0]   s_addr_o,
  output logic [DATA_WIDTH-1:0]   s_wdata_o,
  output logic [DATA_WIDTH/8-1:0] s_wstrb_o,
  input  logic [DATA_WIDTH-1:0]   s_rdata_i,
  input  logic                    s_ready_i,
  output logic [1:0]              grant_o,
  output logic                    err_o,
  input  logic                    err_clr_i
);
  localparam int unsigned CW = TIMEOUT_CYCLES > 0 ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam bit WD_EN = TIMEOUT_CYCLES > 0;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES > 0 ? TIMEOUT_CYCLES - 1 : 0);
  localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT_CYCLES);
  typedef enum logic [1:0] {IDLE, GNT0, GNT1} state_t;
  state_t        r_state;
  state_t        w_next;
  logic          r_last;
  logic [CW-1:0] r_cnt;
  logic          r_err;
  logic          w_gnt0;
  logic          w_gnt1;
  logic          w_gnt;
  logic          w_timeout;
  logic          w_done;
  assign w_gnt0    = r_state == GNT0;
  assign w_gnt1    = r_state == GNT1;
  assign w_gnt     = w_gnt0 | w_gnt1;
  assign w_timeout = WD_EN && w_gnt && !s_ready_i && r_cnt == CNT_LAST;
  assign w_done    = w_gnt && (s_ready_i || w_timeout);
  assign s_valid_o  = w_gnt;
  assign s_addr_o   = w_gnt1 ? m1_addr_i  : w_gnt0 ? m0_addr_i  : '0;
  assign s_wdata_o  = w_gnt1 ? m1_wdata_i : w_gnt0 ? m0_wdata_i : '0;
  assign s_wstrb_o  = w_gnt1 ? m1_wstrb_i : w_gnt0 ? m0_wstrb_i : '0;
  assign grant_o    = {w_gnt1, w_gnt0};
  assign m0_ready_o = w_gnt0 && w_done;
  assign m1_ready_o = w_gnt1 && w_done;
  assign m0_rdata_o = (w_gnt0 && w_timeout) ? TIMEOUT_DATA : s_rdata_i;
  assign m1_rdata_o = (w_gnt1 && w_timeout) ? TIMEOUT_DATA : s_rdata_i;
  assign err_o      = r_err;
  // r_last=1 means master 1 was served last, so a tie goes to master 0
  always_comb begin
    w_next = r_state;
    if (r_state == IDLE)
      w_next = (m0_valid_i && m1_valid_i) ? (r_last ? GNT0 : GNT1) :
               m0_valid_i ? GNT0 : m1_valid_i ? GNT1 : IDLE;
    else if (w_done)
      w_next = IDLE;
  end
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state <= IDLE;
      r_last  <= 1'b1;
      r_cnt   <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_done)
        r_last <= w_gnt1;
      r_cnt <= (!w_gnt || w_done) ? '0 : (r_cnt == CNT_MAX ? r_cnt : r_cnt + 1'b1);
      r_err <= w_timeout | (r_err & ~err_clr_i);
    end
  end
endmodule

// File: tb/tb_sram_arbiter.sv
// tb_sram_arbiter: directed scenarios plus random traffic, every cycle checked
// against a transaction-level model of ownership, fairness and the watchdog.
module tb_sram_arbiter;
  localparam int AW = 19;
  localparam int DW = 32;
  localparam int SW = DW / 8;
  localparam int T  = 8;
  localparam logic [DW-1:0] TDATA = 32'hDEAD_BEEF;
  logic          clk_i = 1'b0;
  logic          rst_i = 1'b0;
  logic          m0_valid_i = 1'b0, m1_valid_i = 1'b0;
  logic [AW-1:0] m0_addr_i = '0, m1_addr_i = '0;
  logic [DW-1:0] m0_wdata_i = '0, m1_wdata_i = '0;
  logic [SW-1:0] m0_wstrb_i = '0, m1_wstrb_i = '0;
  logic [DW-1:0] m0_rdata_o, m1_rdata_o;
  logic          m0_ready_o, m1_ready_o;
  logic          s_valid_o;
  logic [AW-1:0] s_addr_o;
  logic [DW-1:0] s_wdata_o;
  logic [SW-1:0] s_wstrb_o;
  logic [DW-1:0] s_rdata_i = '0;
  logic          s_ready_i = 1'b0;
  logic [1:0]    grant_o;
  logic          err_o;
  logic          err_clr_i = 1'b0;

  sram_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(T), .TIMEOUT_DATA(TDATA)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .m0_valid_i(m0_valid_i), .m0_addr_i(m0_addr_i), .m0_wdata_i(m0_wdata_i), .m0_wstrb_i(m0_wstrb_i),
    .m0_rdata_o(m0_rdata_o), .m0_ready_o(m0_ready_o),
    .m1_valid_i(m1_valid_i), .m1_addr_i(m1_addr_i), .m1_wdata_i(m1_wdata_i), .m1_wstrb_i(m1_wstrb_i),
    .m1_rdata_o(m1_rdata_o), .m1_ready_o(m1_ready_o),
    .s_valid_o(s_valid_o), .s_addr_o(s_addr_o), .s_wdata_o(s_wdata_o), .s_wstrb_o(s_wstrb_o),
    .s_rdata_i(s_rdata_i), .s_ready_i(s_ready_i),
    .grant_o(grant_o), .err_o(err_o), .err_clr_i(err_clr_i)
  );

  always #5 clk_i = ~clk_i;

  int passed = 0;
  int total  = 0;
  int fails  = 0;
  // model: owner is -1 when nobody holds the SRAM, last is the master served most recently
  int owner, last, waited;
  bit merr, m_to, m_done, exp_r0, exp_r1;
  logic [1:0]    obs_gnt;
  logic [AW-1:0] obs_addr;
  logic [SW-1:0] obs_wstrb;
  logic          obs_r0, obs_r1, obs_err;
  logic [DW-1:0] obs_rd0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    owner = -1; last = 1; waited = 0; merr = 0; exp_r0 = 0; exp_r1 = 0;
  endtask

  task automatic compare();
    m_to   = owner >= 0 && !s_ready_i && waited == T - 1;
    m_done = owner >= 0 && (s_ready_i || m_to);
    exp_r0 = owner == 0 && m_done;
    exp_r1 = owner == 1 && m_done;
    check("grant", grant_o, owner == 0 ? 2'b01 : owner == 1 ? 2'b10 : 2'b00);
    check("s_valid", s_valid_o, owner >= 0);
    check("s_addr", s_addr_o, owner == 0 ? m0_addr_i : owner == 1 ? m1_addr_i : '0);
    check("s_wdata", s_wdata_o, owner == 0 ? m0_wdata_i : owner == 1 ? m1_wdata_i : '0);
    check("s_wstrb", s_wstrb_o, owner == 0 ? m0_wstrb_i : owner == 1 ? m1_wstrb_i : '0);
    check("m0_ready", m0_ready_o, exp_r0);
    check("m1_ready", m1_ready_o, exp_r1);
    check("m0_rdata", m0_rdata_o, (owner == 0 && m_to) ? TDATA : s_rdata_i);
    check("m1_rdata", m1_rdata_o, (owner == 1 && m_to) ? TDATA : s_rdata_i);
    check("err", err_o, merr);
    obs_gnt = grant_o; obs_addr = s_addr_o; obs_wstrb = s_wstrb_o;
    obs_r0 = m0_ready_o; obs_r1 = m1_ready_o; obs_rd0 = m0_rdata_o; obs_err = err_o;
  endtask

  task automatic update();
    if (!rst_i) begin
      model_reset();
    end else begin
      if (m_to) merr = 1;
      else if (err_clr_i) merr = 0;
      if (owner < 0) begin
        if (m0_valid_i && m1_valid_i) owner = (last == 0) ? 1 : 0;
        else if (m0_valid_i) owner = 0;
        else if (m1_valid_i) owner = 1;
        waited = 0;
      end else if (m_done) begin
        last = owner; owner = -1; waited = 0;
      end else begin
        waited = waited < T ? waited + 1 : T;
      end
    end
  endtask

  task automatic cycle();
    @(negedge clk_i);
    compare();
    @(posedge clk_i);
    update();
    #1;
  endtask

  task automatic drive();
    if (exp_r0) m0_valid_i = 0;
    if (exp_r1) m1_valid_i = 0;
    if (!m0_valid_i && $urandom_range(0, 2) == 0) begin
      m0_valid_i = 1; m0_addr_i = AW'($urandom); m0_wdata_i = $urandom;
      m0_wstrb_i = $urandom_range(0, 1) ? '0 : SW'($urandom);
    end
    if (!m1_valid_i && $urandom_range(0, 2) == 0) begin
      m1_valid_i = 1; m1_addr_i = AW'($urandom); m1_wdata_i = $urandom;
      m1_wstrb_i = $urandom_range(0, 1) ? '0 : SW'($urandom);
    end
    s_ready_i = $urandom_range(0, 9) < 3;
    s_rdata_i = $urandom;
    err_clr_i = $urandom_range(0, 9) == 0;
  endtask

  initial begin
    logic [1:0] alt_exp [8];
    alt_exp = '{2'b00, 2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b10};
    model_reset();
    cycle();
    cycle();
    rst_i = 1;
    // both masters always requesting, slave always ready: strict alternation with bubbles
    m0_valid_i = 1; m1_valid_i = 1; s_ready_i = 1;
    m0_addr_i = 19'h00100; m1_addr_i = 19'h00200;
    for (int i = 0; i < 8; i++) begin
      cycle();
      check("alt_grant", obs_gnt, alt_exp[i]);
    end
    m0_valid_i = 0; m1_valid_i = 0; s_ready_i = 0;
    cycle();
    // single read from master 0
    m0_valid_i = 1; m0_addr_i = 19'h00010; m0_wstrb_i = '0; s_rdata_i = 32'h1234_5678;
    cycle();
    cycle();
    check("rd_grant", obs_gnt, 2'b01);
    check("rd_addr", obs_addr, 19'h00010);
    s_ready_i = 1;
    cycle();
    check("rd_ready", obs_r0, 1'b1);
    check("rd_data", obs_rd0, 32'h1234_5678);
    check("rd_other_ready", obs_r1, 1'b0);
    m0_valid_i = 0; s_ready_i = 0;
    cycle();
    // master 1 write with a slow slave while master 0 waits
    m1_valid_i = 1; m1_addr_i = 19'h7_0001; m1_wdata_i = 32'hCAFE_F00D; m1_wstrb_i = 4'b0011;
    cycle();
    m0_valid_i = 1; m0_addr_i = 19'h00044;
    for (int i = 0; i < 5; i++) begin
      cycle();
      check("wr_wstrb", obs_wstrb, 4'b0011);
      check("wr_grant", obs_gnt, 2'b10);
    end
    s_ready_i = 1;
    cycle();
    check("wr_ready", obs_r1, 1'b1);
    m1_valid_i = 0; s_ready_i = 0;
    cycle();
    check("wr_bubble", obs_gnt, 2'b00);
    cycle();
    check("wr_next_grant", obs_gnt, 2'b01);
    s_ready_i = 1;
    cycle();
    m0_valid_i = 0; s_ready_i = 0;
    cycle();
    // watchdog: slave never answers
    m0_valid_i = 1; m0_addr_i = 19'h00abc;
    cycle();
    for (int i = 1; i <= T; i++) begin
      cycle();
      check("to_ready", obs_r0, i == T);
      if (i == T) check("to_data", obs_rd0, 32'hDEAD_BEEF);
    end
    m0_valid_i = 0;
    cycle();
    check("to_err_set", obs_err, 1'b1);
    err_clr_i = 1;
    cycle();
    err_clr_i = 0;
    cycle();
    check("to_err_clr", obs_err, 1'b0);
    // asynchronous reset while master 1 owns the slave
    m1_valid_i = 1;
    cycle();
    cycle();
    s_ready_i = 1;
    #1;
    check("pre_rst_ready", m1_ready_o, 1'b1);
    rst_i = 0;
    #1;
    check("rst_s_valid", s_valid_o, 1'b0);
    check("rst_grant", grant_o, 2'b00);
    check("rst_m1_ready", m1_ready_o, 1'b0);
    model_reset();
    s_ready_i = 0; m1_valid_i = 0;
    cycle();
    rst_i = 1; m0_valid_i = 1; m1_valid_i = 1;
    cycle();
    cycle();
    check("post_rst_grant", obs_gnt, 2'b01);
    s_ready_i = 1;
    cycle();
    m0_valid_i = 0; m1_valid_i = 0; s_ready_i = 0;
    exp_r0 = 0; exp_r1 = 0;
    cycle();
    for (int i = 0; i < 600; i++) begin
      drive();
      cycle();
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/sram_arbiter.md
Name: sram_arbiter

Overview:
- Two-master, one-slave arbiter for the external SRAM port.
- Shares the SRAM between the TTA core data bus (master 0) and a second requester (master 1, e.g. UART/DMA engine) using round-robin fairness.
- Grant is locked for the whole transaction, i.e. until the slave handshake completes.
- A programmable watchdog terminates hung slave transactions and flags an error.

Parameters:
- ADDR_WIDTH, 19, word address width on all ports.
- DATA_WIDTH, 32, data width; strobe width is DATA_WIDTH/8.
- TIMEOUT_CYCLES, 1024, granted cycles without s_ready before forced completion; 0 disables the watchdog.
- TIMEOUT_DATA, 32'hDEAD_BEEF, read data returned on a timed-out transaction.

Ports:
- clk_i  in  1  clock; all state changes on the rising edge.
- rst_i  in  1  asynchronous, active-low reset.
- m0_valid_i  in  1  master 0 request; held until m0_ready_o.
- m0_addr_i  in  ADDR_WIDTH  master 0 address.
- m0_wdata_i  in  DATA_WIDTH  master 0 write data.
- m0_wstrb_i  in  DATA_WIDTH/8  master 0 byte strobes; 0 means read.
- m0_rdata_o  out  DATA_WIDTH  read data to master 0.
- m0_ready_o  out  1  master 0 transaction complete (1-cycle pulse).
- m1_valid_i, m1_addr_i, m1_wdata_i, m1_wstrb_i, m1_rdata_o, m1_ready_o: same as m0_*, for master 1.
- s_valid_o  out  1  request to SRAM.
- s_addr_o  out  ADDR_WIDTH  address to SRAM.
- s_wdata_o  out  DATA_WIDTH  write data to SRAM.
- s_wstrb_o  out  DATA_WIDTH/8  strobes to SRAM.
- s_rdata_i  in  DATA_WIDTH  read data from SRAM.
- s_ready_i  in  1  SRAM completion.
- grant_o  out  2  one-hot current grant; 00 when idle.
- err_o  out  1  sticky timeout flag.
- err_clr_i  in  1  clears err_o.

Behaviour:
- States:
  - IDLE: no grant.
  - GNT0: master 0 owns the slave.
  - GNT1: master 1 owns the slave.
- Reset (rst_i=0, asynchronous, effective mid-transaction) forces:
  - state=IDLE, last=1 (master 0 wins the first tie), timeout counter=0, err_o=0.
  - All outputs combinationally derived from state read 0: s_valid_o, m*_ready_o, grant_o.
- IDLE arbitration, evaluated on sampled m*_valid_i:
  - Only one master valid → go to its GNT state.
  - Both valid → grant the master != last.
  - Neither valid → stay in IDLE.
- Latency:
  - A request seen in IDLE at edge N gives s_valid_o=1 from cycle N+1.
  - Minimum transaction is 2 cycles: arbitration plus a slave that is ready immediately.
- Slave-side muxing in GNTx:
  - s_valid_o=1; s_addr_o, s_wdata_o and s_wstrb_o are combinational muxes of master x.
  - In IDLE, s_addr_o, s_wdata_o and s_wstrb_o drive 0.
- Completion in GNTx:
  - mx_ready_o = s_ready_i, combinationally.
  - The other master's ready is 0 at all times.
- Completion edge (s_ready_i=1 in GNTx):
  - last ← x; state → IDLE; counter cleared.
  - One idle bubble is mandatory between transactions.
- Read data: m0_rdata_o and m1_rdata_o both carry s_rdata_i, except during a timeout completion (see watchdog).
- Master protocol violation: dropping mx_valid_i while granted is unsupported. The arbiter holds the grant regardless until completion or timeout.
- Watchdog (TIMEOUT_CYCLES>0):
  - Counter increments each GNT cycle with s_ready_i=0; saturates at TIMEOUT_CYCLES.
  - When counter == TIMEOUT_CYCLES-1 and s_ready_i=0, that cycle becomes the completion cycle:
    - mx_ready_o=1 and mx_rdata_o=TIMEOUT_DATA.
    - s_valid_o stays 1 that cycle.
    - err_o set at the edge; state → IDLE.
- Simultaneous events:
  - s_ready_i on the timeout cycle → normal completion, no error.
  - err_clr_i and a timeout on the same edge → err_o=1 (set wins).
- Width rule: the counter holds TIMEOUT_CYCLES, $clog2(TIMEOUT_CYCLES+1) bits, with 1 as the minimum.

Test Plan:
- Reset released, m0 read at addr 0x00010, s_ready_i asserted 1 cycle after s_valid_o → grant_o=01, s_addr_o=0x00010, m0_ready_o pulses once with s_rdata_i=0x12345678, m1_ready_o=0.
- m0 and m1 valid continuously, slave always ready → grants alternate 01,10,01,10 with one IDLE cycle between; first grant to m0.
- m1 write 0xCAFEF00D, wstrb 4'b0011, slave delays ready 5 cycles while m0 raises valid → s_wstrb_o=0011 held throughout; m0 is not granted until after m1 completes.
- TIMEOUT_CYCLES=8, slave never ready → m0_ready_o pulses on the 8th granted cycle with m0_rdata_o=0xDEADBEEF; err_o=1 next cycle; err_clr_i pulse → err_o=0.
- rst_i asserted low mid-transaction in GNT1 → s_valid_o, grant_o and m1_ready_o drop to 0 without a clock edge; after release, simultaneous requests grant m0 first.
